// File: rtl/sha2_sched_ctrl_pkg.sv
// Shared types and constants for the SHA-256 message schedule sequencer.
// Mirrors the sigma op encoding used by the ibex-crypto sigma unit.
package sha2_sched_ctrl_pkg;

  typedef enum logic [1:0] {
    SHA2_SIG0,
    SHA2_SIG1,
    SHA2_SUM0,
    SHA2_SUM1
  } sha2_op_t;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    EMIT,
    S0,
    S1,
    OUT
  } sha2_sched_state_e;

  localparam int BLOCK_WORDS        = 16;
  localparam int SHA256_SCHED_WORDS = 64;
  localparam int SCHED_WORDS        = SHA256_SCHED_WORDS;

endpackage

// File: rtl/sha2_sched_ctrl_if.sv
// Word streams of the schedule sequencer: message words in, W[t] out.
// master = producer/consumer side, slave = the sequencer.
interface sha2_sched_ctrl_if;

  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [5:0]  out_idx;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_idx
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_idx
  );

endinterface

// File: rtl/sha2_sched_ctrl_buf.sv
// 16x32 circular schedule buffer: one write port, reads at t, t-2, t-7, t-15.
// Offsets wrap on the 4-bit index, so slot t also holds W[t-16].
module sha2_sched_ctrl_buf (
  input  logic        clk,
  input  logic        we,
  input  logic [3:0]  waddr,
  input  logic [31:0] wdata,
  input  logic [3:0]  idx,
  output logic [31:0] rd_t,
  output logic [31:0] rd_t2,
  output logic [31:0] rd_t7,
  output logic [31:0] rd_t15
);

  logic [31:0] mem [16];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rd_t   = mem[idx];
  assign rd_t2  = mem[idx - 4'd2];
  assign rd_t7  = mem[idx - 4'd7];
  assign rd_t15 = mem[idx - 4'd15];

endmodule

// File: rtl/sha2_sched_ctrl.sv
// SHA-256 message schedule sequencer driving a shared sigma unit.
// Optional SHA2_SCHED_STALL_CNT_EN adds an output back-pressure counter.
module sha2_sched_ctrl
  import sha2_sched_ctrl_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic              abort_i,
  sha2_sched_ctrl_if.slave  io,
  output logic              busy_o,
  output logic              done_o,
  output logic              sha2_en_o,
  output sha2_op_t          sha2_op_o,
  output logic [31:0]       sha2_op_a_o,
  input  logic [31:0]       sha2_result_i
`ifdef SHA2_SCHED_STALL_CNT_EN
  ,
  output logic [15:0]       stall_cnt_o
`endif
);

  localparam logic [5:0] BLK_LAST = 6'(BLOCK_WORDS - 1);
  localparam logic [5:0] T_LAST   = 6'(SCHED_WORDS - 1);

  sha2_sched_state_e state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [31:0] s0_q, s0_d;
  logic [31:0] out_q, out_d;
  logic        done_d;
  logic        we;
  logic [31:0] wdata;
  logic [31:0] rd_t, rd_t2, rd_t7, rd_t15;

  sha2_sched_ctrl_buf u_buf (
    .clk    (clk_i),
    .we     (we),
    .waddr  (cnt_q[3:0]),
    .wdata  (wdata),
    .idx    (cnt_q[3:0]),
    .rd_t   (rd_t),
    .rd_t2  (rd_t2),
    .rd_t7  (rd_t7),
    .rd_t15 (rd_t15)
  );

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    s0_d         = s0_q;
    out_d        = out_q;
    done_d       = 1'b0;
    we           = 1'b0;
    wdata        = io.in_data;
    io.in_ready  = 1'b0;
    io.out_valid = 1'b0;
    io.out_data  = '0;
    io.out_idx   = '0;
    sha2_en_o    = 1'b0;
    sha2_op_o    = SHA2_SIG0;
    sha2_op_a_o  = '0;
    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d = LOAD;
          cnt_d   = '0;
        end
      end
      LOAD: begin
        io.in_ready = 1'b1;
        if (io.in_valid) begin
          we    = 1'b1;
          cnt_d = cnt_q + 6'd1;
          if (cnt_q == BLK_LAST) begin
            state_d = EMIT;
            cnt_d   = '0;
          end
        end
      end
      EMIT: begin
        io.out_valid = 1'b1;
        io.out_data  = rd_t;
        io.out_idx   = cnt_q;
        if (io.out_ready) begin
          cnt_d = cnt_q + 6'd1;
          if (cnt_q == BLK_LAST) state_d = S0;
        end
      end
      S0: begin
        sha2_en_o   = 1'b1;
        sha2_op_a_o = rd_t15;
        s0_d        = sha2_result_i;
        state_d     = S1;
      end
      S1: begin
        sha2_en_o   = 1'b1;
        sha2_op_o   = SHA2_SIG1;
        sha2_op_a_o = rd_t2;
        // slot t still holds W[t-16] until this write
        wdata   = sha2_result_i + s0_q + rd_t7 + rd_t;
        we      = 1'b1;
        out_d   = wdata;
        state_d = OUT;
      end
      OUT: begin
        io.out_valid = 1'b1;
        io.out_data  = out_q;
        io.out_idx   = cnt_q;
        if (io.out_ready) begin
          if (cnt_q == T_LAST) begin
            state_d = IDLE;
            cnt_d   = '0;
            done_d  = 1'b1;
          end else begin
            state_d = S0;
            cnt_d   = cnt_q + 6'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    if (abort_i) begin
      state_d = IDLE;
      cnt_d   = '0;
      done_d  = 1'b0;
      we      = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      s0_q    <= '0;
      out_q   <= '0;
      done_o  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      s0_q    <= s0_d;
      out_q   <= out_d;
      done_o  <= done_d;
    end
  end

  assign busy_o = (state_q != IDLE);

`ifdef SHA2_SCHED_STALL_CNT_EN
  logic [15:0] stall_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stall_q <= '0;
    end else if (state_q == IDLE && start_i && !abort_i) begin
      stall_q <= '0;
    end else if (io.out_valid && !io.out_ready
                 && stall_q != 16'hFFFF) begin
      stall_q <= stall_q + 16'd1;
    end
  end

  assign stall_cnt_o = stall_q;
`endif

endmodule

// File: tb/tb_sha2_sched_ctrl.sv
// Scoreboard bench for sha2_sched_ctrl with a behavioural sigma unit.
// Stall counter checks are built only with SHA2_SCHED_STALL_CNT_EN.
module tb_sha2_sched_ctrl;
  import sha2_sched_ctrl_pkg::*;

  typedef logic [31:0] blk_t [16];
  typedef struct packed {
    logic [5:0]  idx;
    logic [31:0] data;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic        busy, done, sha2_en;
  sha2_op_t    sha2_op;
  logic [31:0] op_a, result;
`ifdef SHA2_SCHED_STALL_CNT_EN
  logic [15:0] stall_cnt;
`endif

  int   cmp_n = 0;
  int   err_n = 0;
  int   cyc = 0;
  exp_t sb[$];

  sha2_sched_ctrl_if io ();

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] ror(logic [31:0] x, int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] sig0(logic [31:0] x);
    return ror(x, 7) ^ ror(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] sig1(logic [31:0] x);
    return ror(x, 17) ^ ror(x, 19) ^ (x >> 10);
  endfunction

  assign result = (sha2_op == SHA2_SIG1) ? sig1(op_a) : sig0(op_a);

  sha2_sched_ctrl dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .start_i       (start),
    .abort_i       (abort),
    .io            (io.slave),
    .busy_o        (busy),
    .done_o        (done),
    .sha2_en_o     (sha2_en),
    .sha2_op_o     (sha2_op),
    .sha2_op_a_o   (op_a),
    .sha2_result_i (result)
`ifdef SHA2_SCHED_STALL_CNT_EN
    ,
    .stall_cnt_o   (stall_cnt)
`endif
  );

  function automatic blk_t abc_blk();
    blk_t b;
    for (int i = 0; i < 16; i++) b[i] = '0;
    b[0]  = 32'h61626380;
    b[15] = 32'h00000018;
    return b;
  endfunction

  function automatic blk_t rand_blk();
    blk_t b;
    for (int i = 0; i < 16; i++) b[i] = $urandom;
    return b;
  endfunction

  task automatic push_golden(input blk_t blk);
    logic [31:0] w [64];
    exp_t e;
    for (int i = 0; i < 16; i++) w[i] = blk[i];
    for (int i = 16; i < 64; i++)
      w[i] = sig1(w[i-2]) + w[i-7] + sig0(w[i-15]) + w[i-16];
    for (int i = 0; i < 64; i++) begin
      e.idx  = 6'(i);
      e.data = w[i];
      sb.push_back(e);
    end
  endtask

  task automatic run_block(input blk_t blk, input int rdy_pct,
                           input bit gaps, input int abort_at,
                           input bit start_emit, input int stall_at,
                           input bit chk_lat, input bit chk_abc);
    int          t0, popped, dones, stall_left;
    bit          prev_st, fin, rdy;
    logic [31:0] pd;
    logic [5:0]  pi;
    exp_t        e;
    sb.delete();
    push_golden(blk);
    t0 = 0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cmp_n++;
    if (busy !== 1'b1) begin
      err_n++;
      $display("FAIL start_busy got=%b want=1", busy);
    end
    for (int i = 0; i < 16; i++) begin
      for (int g = 0; g < 2 && gaps && $urandom_range(0, 2) == 0; g++) begin
        io.in_valid = 1'b0;
        @(negedge clk);
      end
      io.in_valid = 1'b1;
      io.in_data  = blk[i];
      cmp_n++;
      if (io.in_ready !== 1'b1) begin
        err_n++;
        $display("FAIL load_ready word=%0d got=%b want=1", i, io.in_ready);
      end
      if (i == 0) t0 = cyc;
      @(negedge clk);
    end
    io.in_valid = 1'b0;
    popped = 0; dones = 0; prev_st = 0; fin = 0; stall_left = 10;
    pd = '0; pi = '0;
    for (int c = 0; c < 3000 && !fin; c++) begin
      if (prev_st) begin
        cmp_n++;
        if (io.out_valid !== 1'b1 || io.out_data !== pd || io.out_idx !== pi) begin
          err_n++;
          $display("FAIL stall_stable got=%b/%h/%0d want=1/%h/%0d",
                   io.out_valid, io.out_data, io.out_idx, pd, pi);
        end
      end
      if (done === 1'b1) begin
        dones++;
        fin = 1;
        if (chk_lat) begin
          cmp_n++;
          if (cyc - t0 != 176) begin
            err_n++;
            $display("FAIL latency got=%0d want=176", cyc - t0);
          end
        end
      end
      cmp_n++;
      if (io.in_ready !== 1'b0) begin
        err_n++;
        $display("FAIL ready_outside_load got=%b want=0", io.in_ready);
      end
      if (!sha2_en) begin
        cmp_n++;
        if (op_a !== 32'h0) begin
          err_n++;
          $display("FAIL op_a_gated got=%h want=0", op_a);
        end
      end
      start = start_emit && io.out_valid && io.out_idx == 6'd3 && popped == 3;
      rdy = ($urandom_range(0, 99) < rdy_pct);
      if (stall_at >= 0 && io.out_valid && io.out_idx == stall_at[5:0]
          && stall_left > 0) begin
        rdy = 1'b0;
        stall_left--;
      end
      io.out_ready = rdy;
      if (abort_at >= 0 && popped == abort_at && sha2_en
          && sha2_op == SHA2_SIG1) begin
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        cmp_n++;
        if (busy !== 1'b0 || io.out_valid !== 1'b0) begin
          err_n++;
          $display("FAIL abort_idle busy=%b valid=%b want=0/0", busy, io.out_valid);
        end
        repeat (4) begin
          @(negedge clk);
          cmp_n++;
          if (done !== 1'b0) begin
            err_n++;
            $display("FAIL abort_no_done got=%b want=0", done);
          end
        end
        sb.delete();
        io.out_ready = 1'b0;
        return;
      end
      if (io.out_valid && rdy) begin
        cmp_n++;
        if (sb.size() == 0) begin
          err_n++;
          $display("FAIL extra_word idx=%0d want=none", io.out_idx);
        end else begin
          e = sb.pop_front();
          if (io.out_idx !== e.idx || io.out_data !== e.data) begin
            err_n++;
            $display("FAIL word got=%0d/%h want=%0d/%h",
                     io.out_idx, io.out_data, e.idx, e.data);
          end
        end
        if (chk_abc && (io.out_idx == 6'd16 || io.out_idx == 6'd17)) begin
          cmp_n++;
          if (io.out_data !== (io.out_idx == 6'd16 ? 32'h61626380 : 32'h000F0000)) begin
            err_n++;
            $display("FAIL abc_w%0d got=%h", io.out_idx, io.out_data);
          end
        end
        popped++;
      end
      prev_st = io.out_valid && !rdy;
      pd = io.out_data;
      pi = io.out_idx;
      @(negedge clk);
    end
    start = 1'b0;
    cmp_n++;
    if (!fin || popped != 64 || sb.size() != 0) begin
      err_n++;
      $display("FAIL block_end done_seen=%0d popped=%0d left=%0d want=1/64/0",
               fin, popped, sb.size());
    end
    repeat (3) begin
      cmp_n++;
      if (done !== 1'b0) begin
        err_n++;
        $display("FAIL done_once got=%b want=0", done);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    cmp_n++;
    if ({busy, done, io.in_ready, io.out_valid, sha2_en} !== 5'b0) begin
      err_n++;
      $display("FAIL reset_ctl got=%b want=00000",
               {busy, done, io.in_ready, io.out_valid, sha2_en});
    end
    cmp_n++;
    if (io.out_data !== 32'h0 || io.out_idx !== 6'h0 || op_a !== 32'h0
        || sha2_op !== SHA2_SIG0) begin
      err_n++;
      $display("FAIL reset_data got=%h/%0d/%h/%0d want=0/0/0/SIG0",
               io.out_data, io.out_idx, op_a, sha2_op);
    end
`ifdef SHA2_SCHED_STALL_CNT_EN
    cmp_n++;
    if (stall_cnt !== 16'h0) begin
      err_n++;
      $display("FAIL reset_stall got=%0d want=0", stall_cnt);
    end
`endif
    rst = 1'b0;
  endtask

  task automatic test_abc();
    run_block(abc_blk(), 100, 0, -1, 0, -1, 1, 1);
  endtask

  task automatic test_back_pressure();
    run_block(rand_blk(), 50, 1, -1, 0, -1, 0, 0);
  endtask

  task automatic test_abort();
    run_block(abc_blk(), 100, 0, 30, 0, -1, 0, 0);
    run_block(abc_blk(), 70, 0, -1, 0, -1, 0, 1);
  endtask

  task automatic test_start_in_emit();
    run_block(rand_blk(), 100, 0, -1, 1, -1, 0, 0);
  endtask

  task automatic test_reset_mid_load();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 7; i++) begin
      io.in_valid = 1'b1;
      io.in_data  = $urandom;
      @(negedge clk);
    end
    io.in_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    cmp_n++;
    if ({busy, done, io.in_ready, io.out_valid, sha2_en} !== 5'b0
        || op_a !== 32'h0 || io.out_data !== 32'h0) begin
      err_n++;
      $display("FAIL reset_mid_load ctl=%b op_a=%h data=%h want=0",
               {busy, done, io.in_ready, io.out_valid, sha2_en}, op_a, io.out_data);
    end
    rst = 1'b0;
    run_block(rand_blk(), 100, 0, -1, 0, -1, 1, 0);
  endtask

`ifdef SHA2_SCHED_STALL_CNT_EN
  task automatic test_stall_cnt();
    run_block(rand_blk(), 100, 0, -1, 0, 5, 0, 0);
    cmp_n++;
    if (stall_cnt !== 16'd10) begin
      err_n++;
      $display("FAIL stall_cnt got=%0d want=10", stall_cnt);
    end
  endtask
`endif

  initial begin
    io.in_valid  = 1'b0;
    io.in_data   = '0;
    io.out_ready = 1'b0;
    test_reset();
    test_abc();
    test_back_pressure();
    test_abort();
    test_start_in_emit();
    test_reset_mid_load();
`ifdef SHA2_SCHED_STALL_CNT_EN
    test_stall_cnt();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_n, err_n);
    $finish;
  end

endmodule
